// File: rtl/sm_trace_if.sv
// Control, status and read-back signals of the schoolMIPS trace buffer.
// The master side is the CPU/debug host and the slave side is the buffer.
interface sm_trace_if #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CYCLE_WIDTH = 16
);
  logic                   sampleEn;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   arm;
  logic                   trigEnable;
  logic [PC_WIDTH-1:0]    trigPc;
  logic [DEPTH_LOG2-1:0]  postCount;
  logic [CYCLE_WIDTH-1:0] timeoutLimit;
  logic [DEPTH_LOG2-1:0]  rdIndex;

  logic [1:0]             state;
  logic [DEPTH_LOG2:0]    entries;
  logic [DEPTH_LOG2-1:0]  trigIndex;
  logic                   timedOut;
  logic                   rdValid;
  logic [PC_WIDTH-1:0]    rdPc;
  logic [INSTR_WIDTH-1:0] rdInstr;
  logic [CYCLE_WIDTH-1:0] rdCycle;

  modport master (
    output sampleEn, pc, instr, arm, trigEnable, trigPc, postCount, timeoutLimit, rdIndex,
    input  state, entries, trigIndex, timedOut, rdValid, rdPc, rdInstr, rdCycle
  );

  modport slave (
    input  sampleEn, pc, instr, arm, trigEnable, trigPc, postCount, timeoutLimit, rdIndex,
    output state, entries, trigIndex, timedOut, rdValid, rdPc, rdInstr, rdCycle
  );
endinterface

// File: rtl/sm_trace_buffer.sv
// Circular execution trace buffer: captures (pc, instr, cycle stamp) per enabled
// CPU cycle, freezes on a PC trigger plus post count or on timeout, reads oldest-first.
module sm_trace_buffer #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CYCLE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  sm_trace_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned DL    = DEPTH_LOG2;
  localparam int unsigned CW    = CYCLE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DL-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DL:0]     entries_q, entries_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DL-1:0]   trig_addr_q, trig_addr_d;
  logic            triggered_q, triggered_d;
  logic [DL-1:0]   remaining_q, remaining_d;
  logic            timed_out_q, timed_out_d;
  logic [DL-1:0]   trig_index_q, trig_index_d;

  logic                   rd_valid_q, rd_valid_d;
  logic [PC_WIDTH-1:0]    rd_pc_q;
  logic [INSTR_WIDTH-1:0] rd_instr_q;
  logic [CW-1:0]          rd_cycle_q;

  logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [CW-1:0]          mem_cycle [DEPTH];

  logic          we_c;
  logic          capture_c;
  logic          trig_hit_c;
  logic          timeout_hit_c;
  logic [DL-1:0] oldest_d_c;
  logic [DL-1:0] rd_addr_c;

  // Next-state logic; postCount is DL bits wide so it never exceeds DEPTH-1.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    entries_d     = entries_q;
    cnt_d         = cnt_q;
    trig_addr_d   = trig_addr_q;
    triggered_d   = triggered_q;
    remaining_d   = remaining_q;
    timed_out_d   = timed_out_q;
    capture_c     = 1'b0;
    we_c          = 1'b0;

    trig_hit_c    = bus.trigEnable && bus.sampleEn && (bus.pc == bus.trigPc);
    timeout_hit_c = bus.trigEnable && (bus.timeoutLimit != '0) &&
                    (cnt_q == CW'(bus.timeoutLimit - CW'(1)));

    if (bus.arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      entries_d   = '0;
      cnt_d       = '0;
      trig_addr_d = '0;
      triggered_d = 1'b0;
      remaining_d = '0;
      timed_out_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          cnt_d     = cnt_q + CW'(1);
          capture_c = bus.sampleEn;
          if (trig_hit_c) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            remaining_d = bus.postCount;
            state_d     = (bus.postCount == '0) ? S_DONE : S_POST;
          end else if (timeout_hit_c) begin
            state_d     = S_DONE;
            timed_out_d = 1'b1;
          end
        end
        S_POST: begin
          cnt_d     = cnt_q + CW'(1);
          capture_c = bus.sampleEn;
          if (bus.sampleEn) begin
            remaining_d = remaining_q - DL'(1);
            if (remaining_q == DL'(1)) state_d = S_DONE;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (capture_c) begin
      we_c     = 1'b1;
      wr_ptr_d = wr_ptr_q + DL'(1);
      if (entries_q != (DL+1)'(DEPTH)) entries_d = entries_q + (DL+1)'(1);
    end

    oldest_d_c   = wr_ptr_d - entries_d[DL-1:0];
    trig_index_d = triggered_d ? DL'(trig_addr_d - oldest_d_c) : '0;

    rd_addr_c  = DL'(wr_ptr_q - entries_q[DL-1:0] + bus.rdIndex);
    rd_valid_d = ((DL+1)'(bus.rdIndex) < entries_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      entries_q    <= '0;
      cnt_q        <= '0;
      trig_addr_q  <= '0;
      triggered_q  <= 1'b0;
      remaining_q  <= '0;
      timed_out_q  <= 1'b0;
      trig_index_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      entries_q    <= entries_d;
      cnt_q        <= cnt_d;
      trig_addr_q  <= trig_addr_d;
      triggered_q  <= triggered_d;
      remaining_q  <= remaining_d;
      timed_out_q  <= timed_out_d;
      trig_index_q <= trig_index_d;
    end
  end

  // Sample RAM; contents need no reset since entries gates visibility.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_pc[wr_ptr_q]    <= bus.pc;
      mem_instr[wr_ptr_q] <= bus.instr;
      mem_cycle[wr_ptr_q] <= cnt_q;
    end
  end

  // Registered read port; a same-edge write to the slot yields the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
      rd_cycle_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_pc_q    <= rd_valid_d ? mem_pc[rd_addr_c]    : '0;
      rd_instr_q <= rd_valid_d ? mem_instr[rd_addr_c] : '0;
      rd_cycle_q <= rd_valid_d ? mem_cycle[rd_addr_c] : '0;
    end
  end

  assign bus.state     = state_q;
  assign bus.entries   = entries_q;
  assign bus.trigIndex = trig_index_q;
  assign bus.timedOut  = timed_out_q;
  assign bus.rdValid   = rd_valid_q;
  assign bus.rdPc      = rd_pc_q;
  assign bus.rdInstr   = rd_instr_q;
  assign bus.rdCycle   = rd_cycle_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the captured history.
module tb_sm_trace_buffer;

  localparam int DL    = 4;
  localparam int PW    = 32;
  localparam int IW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_trace_if #(.DEPTH_LOG2(DL), .PC_WIDTH(PW), .INSTR_WIDTH(IW), .CYCLE_WIDTH(CW)) bus ();

  sm_trace_buffer #(.DEPTH_LOG2(DL), .PC_WIDTH(PW), .INSTR_WIDTH(IW), .CYCLE_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: history as queues, trigger tracked as an absolute sample number.
  int          m_state;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  int          q_cyc[$];
  int          m_cnt;
  int          m_total;
  int          m_trig;
  int          m_rem;
  int          m_timed;
  int          e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_instr;
  int          e_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    q_pc.delete(); q_instr.delete(); q_cyc.delete();
    m_cnt = 0; m_total = 0; m_trig = -1; m_rem = 0; m_timed = 0;
    e_valid = 0; e_pc = 0; e_instr = 0; e_cyc = 0;
  endtask

  task automatic push_sample(input int stamp);
    q_pc.push_back(bus.pc);
    q_instr.push_back(bus.instr);
    q_cyc.push_back(stamp);
    if (q_pc.size() > DEPTH) begin
      void'(q_pc.pop_front()); void'(q_instr.pop_front()); void'(q_cyc.pop_front());
    end
    m_total++;
  endtask

  task automatic model_step();
    int idx;
    int stamp;
    idx = int'(bus.rdIndex);
    e_valid = (idx < q_pc.size()) ? 1 : 0;
    e_pc    = e_valid ? q_pc[idx]    : 32'd0;
    e_instr = e_valid ? q_instr[idx] : 32'd0;
    e_cyc   = e_valid ? q_cyc[idx]   : 0;
    if (bus.arm) begin
      m_state = 1;
      q_pc.delete(); q_instr.delete(); q_cyc.delete();
      m_cnt = 0; m_total = 0; m_trig = -1; m_timed = 0;
    end else if (m_state == 1 || m_state == 2) begin
      stamp = m_cnt;
      m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_state == 1) begin
        if (bus.sampleEn) push_sample(stamp);
        if (bus.trigEnable && bus.sampleEn && bus.pc == bus.trigPc) begin
          m_trig = m_total - 1;
          m_rem  = int'(bus.postCount);
          m_state = (m_rem == 0) ? 3 : 2;
        end else if (bus.trigEnable && bus.timeoutLimit != 0 &&
                     stamp == int'(bus.timeoutLimit) - 1) begin
          m_state = 3;
          m_timed = 1;
        end
      end else if (bus.sampleEn) begin
        push_sample(stamp);
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_ti;
    exp_ti = (m_trig >= 0) ? (m_trig - (m_total - q_pc.size())) : 0;
    check_eq({tag, "_state"},   64'(bus.state),     64'(m_state));
    check_eq({tag, "_entries"}, 64'(bus.entries),   64'(q_pc.size()));
    check_eq({tag, "_trigidx"}, 64'(bus.trigIndex), 64'(exp_ti));
    check_eq({tag, "_timeout"}, 64'(bus.timedOut),  64'(m_timed));
    check_eq({tag, "_rdvalid"}, 64'(bus.rdValid),   64'(e_valid));
    check_eq({tag, "_rdpc"},    64'(bus.rdPc),      64'(e_pc));
    check_eq({tag, "_rdinstr"}, 64'(bus.rdInstr),   64'(e_instr));
    check_eq({tag, "_rdcycle"}, 64'(bus.rdCycle),   64'(e_cyc));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic samp(input string tag, input logic en, input logic [31:0] pcv);
    bus.sampleEn = en;
    bus.pc       = pcv;
    bus.instr    = $urandom;
    bus.rdIndex  = DL'($urandom_range(0, DEPTH - 1));
    step(tag);
  endtask

  task automatic rd(input string tag, input int idx);
    bus.sampleEn = 1'b0;
    bus.rdIndex  = DL'(idx);
    step(tag);
  endtask

  task automatic do_arm(input logic en);
    bus.arm      = 1'b1;
    bus.sampleEn = en;
    bus.pc       = $urandom;
    bus.instr    = $urandom;
    step("arm");
    bus.arm      = 1'b0;
  endtask

  initial begin
    bus.sampleEn = 0; bus.pc = 0; bus.instr = 0; bus.arm = 0; bus.trigEnable = 0;
    bus.trigPc = 0; bus.postCount = 0; bus.timeoutLimit = 0; bus.rdIndex = 0;
    model_reset();
    #12;
    check_all("reset");
    #10 rst_n = 1'b1;

    // Rolling window, short fill
    do_arm(1'b0);
    for (int i = 0; i < 5; i++) samp("t1", 1'b1, 32'(i));
    check_eq("t1_entries5", 64'(bus.entries), 64'd5);
    check_eq("t1_armed", 64'(bus.state), 64'd1);
    for (int i = 0; i <= 5; i++) begin
      rd("t1_rd", i);
      check_eq("t1_rdpc_idx", 64'(bus.rdPc), (i < 5) ? 64'(i) : 64'd0);
    end

    // Rolling window, wrapped
    do_arm(1'b0);
    for (int i = 0; i < 20; i++) samp("t2", 1'b1, 32'(i));
    check_eq("t2_entries16", 64'(bus.entries), 64'd16);
    rd("t2_rd", 0);  check_eq("t2_oldest", 64'(bus.rdPc), 64'd4);
    rd("t2_rd", 15); check_eq("t2_newest", 64'(bus.rdPc), 64'd19);

    // PC trigger with post count 3
    bus.trigEnable = 1; bus.trigPc = 10; bus.postCount = 3; bus.timeoutLimit = 0;
    do_arm(1'b0);
    for (int i = 0; i <= 30; i++) begin
      samp("t3", 1'b1, 32'(i));
      if (i == 12) check_eq("t3_post", 64'(bus.state), 64'd2);
      if (i == 13) check_eq("t3_done", 64'(bus.state), 64'd3);
    end
    check_eq("t3_entries", 64'(bus.entries), 64'd14);
    check_eq("t3_trigidx", 64'(bus.trigIndex), 64'd10);
    check_eq("t3_timedout", 64'(bus.timedOut), 64'd0);
    rd("t3_rd", 13); check_eq("t3_last", 64'(bus.rdPc), 64'd13);

    // Maximal post count keeps the trigger sample as the oldest
    bus.trigPc = 3; bus.postCount = 15;
    do_arm(1'b0);
    for (int i = 0; i <= 40; i++) begin
      samp("t4", 1'b1, 32'(i));
      if (i == 18) check_eq("t4_done", 64'(bus.state), 64'd3);
    end
    check_eq("t4_trigidx", 64'(bus.trigIndex), 64'd0);
    rd("t4_rd", 0);  check_eq("t4_oldest", 64'(bus.rdPc), 64'd3);
    rd("t4_rd", 15); check_eq("t4_newest", 64'(bus.rdPc), 64'd18);

    // Timeout after 8 clocks, then trigger on the 8th cycle wins
    bus.trigPc = 32'hDEAD_0000; bus.postCount = 0; bus.timeoutLimit = 8;
    do_arm(1'b0);
    for (int k = 1; k <= 8; k++) begin
      samp("t5", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 99)));
      if (k == 7) check_eq("t5_armed7", 64'(bus.state), 64'd1);
    end
    check_eq("t5_done8", 64'(bus.state), 64'd3);
    check_eq("t5_timedout", 64'(bus.timedOut), 64'd1);
    bus.postCount = 2;
    do_arm(1'b0);
    for (int k = 1; k < 8; k++) samp("t5b", 1'b1, 32'(k));
    samp("t5b", 1'b1, 32'hDEAD_0000);
    check_eq("t5b_post", 64'(bus.state), 64'd2);
    check_eq("t5b_notimeout", 64'(bus.timedOut), 64'd0);

    // Asynchronous reset in POST
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_arm(1'b1);
    check_eq("t6_arm_discard", 64'(bus.entries), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.trigEnable   = 1'($urandom_range(0, 3) != 0);
        bus.trigPc       = 32'($urandom_range(0, 31));
        bus.postCount    = DL'($urandom_range(0, DEPTH - 1));
        bus.timeoutLimit = CW'($urandom_range(0, 40));
        do_arm(1'($urandom_range(0, 1)));
      end else begin
        samp("rnd", 1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
